vita49_unpack: RTL and testbench

- Receive side of the VITA-49 IF-data link: accepts big-endian VITA-49 packets on an AXI-Stream slave.
- Parses and strips the header, stream ID, integer timestamp, fractional timestamp and optional trailer.
- Emits the payload as a little-endian AXI-Stream, with TLAST on the last payload word of each packet.
- Exposes the captured timestamp, trailer and status/error information to the processor; sits between the link/DMA input and the sample sink.

---
 rtl/vita49_unpack.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_vita49_unpack.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vita49_unpack.sv
// VITA-49 receive unpacker: strips header/ID/timestamps/trailer from a
// big-endian AXI-Stream and emits the payload little-endian with TLAST.
//
// Ports:
//   AXIS_ACLK, AXIS_ARESETN        clock, async active-low reset
//   S_AXIS_*                       packet input (big-endian words)
//   M_AXIS_*                       payload output (little-endian words)
//   ctrl                           [0] enable [1] soft reset
//                                  [2] passthrough [3] stream-ID filter
//   streamID                       expected stream ID when filtering
//   status                         {count, 0, errors, last seq, state}
//   timestamp_sec, timestamp_fsec  last captured timestamps
//   trailer                        last trailer word
//   ts_valid                       one-cycle pulse on timestamp update
module vita49_unpack #(
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESETN,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    input  logic        S_AXIS_TLAST,
    output logic        S_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    output logic        M_AXIS_TLAST,
    input  logic        M_AXIS_TREADY,
    input  logic [31:0] ctrl,
    input  logic [31:0] streamID,
    output logic [31:0] status,
    output logic [31:0] timestamp_sec,
    output logic [63:0] timestamp_fsec,
    output logic [31:0] trailer,
    output logic        ts_valid
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        STRM_ID = 4'd1,
        TSI     = 4'd2,
        TSF_0   = 4'd3,
        TSF_1   = 4'd4,
        PAYLOAD = 4'd5,
        TRAIL   = 4'd6,
        DROP    = 4'd7
    } state_t;

    state_t state, state_n;

    logic [3:0]  ctrl_q;
    logic [31:0] sid_q;
    logic        en_q;
    logic        enable, srst, pass, filt, en_rise;
    logic        unused_ctrl;

    assign enable      = ctrl_q[0];
    assign srst        = ctrl_q[1];
    assign pass        = ctrl_q[2];
    assign filt        = ctrl_q[3];
    assign en_rise     = enable & ~en_q;
    assign unused_ctrl = ^ctrl[31:4];

    logic [31:0] swp;
    logic [3:0]  htype, hseq;
    logic        ht;
    logic [15:0] hsize;

    assign swp   = {S_AXIS_TDATA[7:0], S_AXIS_TDATA[15:8],
                    S_AXIS_TDATA[23:16], S_AXIS_TDATA[31:24]};
    assign htype = swp[31:28];
    assign ht    = swp[26];
    assign hseq  = swp[19:16];
    assign hsize = swp[15:0];

    logic [15:0] wcnt, size_r, last_idx, plast_idx;
    logic        t_r;
    logic [3:0]  seq_exp, last_seq;
    logic        seq_have, seq_bad;
    logic        seq_err, len_err, type_err, sid_err;
    logic [ERR_CNT_WIDTH-1:0] pkt_cnt;
    logic [31:0] tsi_q, tsf_hi_q;

    assign last_idx  = size_r - 16'd1;
    assign plast_idx = last_idx - {15'd0, t_r};

    logic        rdy, acc, load, ld_last;
    logic [31:0] ld_data;
    logic        hdr_ok, e_len, e_type, e_sid;
    logic        pkt_done, ts_upd, trl_ld, step;

    assign acc = S_AXIS_TVALID & rdy;

    always_comb begin
        state_n  = state;
        rdy      = 1'b0;
        load     = 1'b0;
        ld_last  = 1'b0;
        ld_data  = swp;
        hdr_ok   = 1'b0;
        e_len    = 1'b0;
        e_type   = 1'b0;
        e_sid    = 1'b0;
        pkt_done = 1'b0;
        ts_upd   = 1'b0;
        trl_ld   = 1'b0;
        step     = 1'b0;
        if (srst) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pass) begin
                        // Raw forwarding: no parsing, no swap.
                        rdy = ~M_AXIS_TVALID | M_AXIS_TREADY;
                        if (acc) begin
                            load    = 1'b1;
                            ld_data = S_AXIS_TDATA;
                            ld_last = S_AXIS_TLAST;
                        end
                    end else begin
                        rdy = enable;
                        if (acc) begin
                            if (htype != 4'b0001) begin
                                e_type  = 1'b1;
                                state_n = S_AXIS_TLAST ? IDLE : DROP;
                            end else if (hsize < 16'd6 + {15'd0, ht}) begin
                                e_len   = 1'b1;
                                state_n = S_AXIS_TLAST ? IDLE : DROP;
                            end else begin
                                hdr_ok = 1'b1;
                                if (S_AXIS_TLAST) begin
                                    e_len = 1'b1;
                                end else begin
                                    state_n = STRM_ID;
                                end
                            end
                        end
                    end
                end
                STRM_ID, TSI, TSF_0, TSF_1: begin
                    rdy = 1'b1;
                    if (acc) begin
                        step   = 1'b1;
                        ts_upd = (state == TSF_1);
                        e_sid  = (state == STRM_ID) & filt & (swp != sid_q);
                        if (S_AXIS_TLAST) begin
                            e_len   = 1'b1;
                            state_n = IDLE;
                        end else if (e_sid) begin
                            state_n = DROP;
                        end else begin
                            state_n = state_t'(state + 4'd1);
                        end
                    end
                end
                PAYLOAD: begin
                    rdy = ~M_AXIS_TVALID | M_AXIS_TREADY;
                    if (acc) begin
                        step    = 1'b1;
                        load    = 1'b1;
                        ld_last = (wcnt == plast_idx) | S_AXIS_TLAST;
                        if (wcnt == plast_idx) begin
                            if (t_r) begin
                                // TLAST here means the trailer is missing.
                                e_len   = S_AXIS_TLAST;
                                state_n = S_AXIS_TLAST ? IDLE : TRAIL;
                            end else begin
                                pkt_done = S_AXIS_TLAST;
                                e_len    = ~S_AXIS_TLAST;
                                state_n  = S_AXIS_TLAST ? IDLE : DROP;
                            end
                        end else if (S_AXIS_TLAST) begin
                            e_len   = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end
                TRAIL: begin
                    rdy = 1'b1;
                    if (acc) begin
                        trl_ld   = 1'b1;
                        pkt_done = S_AXIS_TLAST;
                        e_len    = ~S_AXIS_TLAST;
                        state_n  = S_AXIS_TLAST ? IDLE : DROP;
                    end
                end
                DROP: begin
                    rdy = 1'b1;
                    if (acc && S_AXIS_TLAST) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign S_AXIS_TREADY = rdy;

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            ctrl_q <= '0;
            sid_q  <= '0;
            en_q   <= 1'b0;
        end else begin
            ctrl_q <= ctrl[3:0];
            sid_q  <= streamID;
            en_q   <= ctrl_q[0];
        end
    end

    // One-entry output register; a load and a drain in the same cycle
    // keep it full.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
        end else if (srst) begin
            M_AXIS_TVALID <= 1'b0;
        end else if (load) begin
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= ld_data;
            M_AXIS_TLAST  <= ld_last;
        end else if (M_AXIS_TREADY) begin
            M_AXIS_TVALID <= 1'b0;
        end
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            wcnt     <= '0;
            size_r   <= '0;
            t_r      <= 1'b0;
            seq_exp  <= '0;
            seq_have <= 1'b0;
            seq_bad  <= 1'b0;
            last_seq <= '0;
            seq_err  <= 1'b0;
            len_err  <= 1'b0;
            type_err <= 1'b0;
            sid_err  <= 1'b0;
            pkt_cnt  <= '0;
        end else if (srst) begin
            seq_have <= 1'b0;
            seq_bad  <= 1'b0;
            last_seq <= '0;
            seq_err  <= 1'b0;
            len_err  <= 1'b0;
            type_err <= 1'b0;
            sid_err  <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            if (en_rise) begin
                seq_have <= 1'b0;
            end
            if (hdr_ok) begin
                wcnt     <= 16'd1;
                size_r   <= hsize;
                t_r      <= ht;
                last_seq <= hseq;
                seq_exp  <= hseq + 4'd1;
                seq_have <= 1'b1;
                // A mismatch resyncs to the received sequence number.
                seq_bad  <= seq_have & ~en_rise & (hseq != seq_exp);
                if (seq_have && !en_rise && hseq != seq_exp) begin
                    seq_err <= 1'b1;
                end
            end else if (step) begin
                wcnt <= wcnt + 16'd1;
            end
            if (e_len)  len_err  <= 1'b1;
            if (e_type) type_err <= 1'b1;
            if (e_sid)  sid_err  <= 1'b1;
            if (pkt_done && !seq_bad) begin
                pkt_cnt <= pkt_cnt + ERR_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            tsi_q          <= '0;
            tsf_hi_q       <= '0;
            timestamp_sec  <= '0;
            timestamp_fsec <= '0;
            trailer        <= '0;
            ts_valid       <= 1'b0;
        end else begin
            ts_valid <= ts_upd;
            if (acc && state == TSI)   tsi_q    <= swp;
            if (acc && state == TSF_0) tsf_hi_q <= swp;
            if (ts_upd) begin
                timestamp_sec  <= tsi_q;
                timestamp_fsec <= {tsf_hi_q, swp};
            end
            if (trl_ld) trailer <= swp;
        end
    end

    assign status = {16'(pkt_cnt), 4'd0, sid_err, type_err,
                     len_err, seq_err, last_seq, state};

endmodule

// File: tb/tb_vita49_unpack.sv
// Directed bench for vita49_unpack: packets built in host byte order,
// sent byte-swapped, payload compared against an expected queue.
module tb_vita49_unpack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic [31:0] ctrl = '0;
    logic [31:0] sid = '0;
    logic [31:0] status;
    logic [31:0] ts_sec;
    logic [63:0] ts_fsec;
    logic [31:0] trl;
    logic        ts_valid;

    always #5 clk = ~clk;

    vita49_unpack #(.ERR_CNT_WIDTH(16)) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESETN  (rst_n),
        .S_AXIS_TDATA  (s_data),
        .S_AXIS_TVALID (s_valid),
        .S_AXIS_TLAST  (s_last),
        .S_AXIS_TREADY (s_ready),
        .M_AXIS_TDATA  (m_data),
        .M_AXIS_TVALID (m_valid),
        .M_AXIS_TLAST  (m_last),
        .M_AXIS_TREADY (m_ready),
        .ctrl          (ctrl),
        .streamID      (sid),
        .status        (status),
        .timestamp_sec (ts_sec),
        .timestamp_fsec(ts_fsec),
        .trailer       (trl),
        .ts_valid      (ts_valid)
    );

    int checks = 0;
    int failures = 0;
    int ts_cnt = 0;
    int pkt_n = 0;
    bit saw_drop = 1'b0;
    bit rnd = 1'b0;
    bit hold = 1'b1;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        m_ready = rnd ? 1'($urandom_range(0, 1)) : hold;
    end

    always @(negedge clk) begin
        if (m_valid && m_ready) got_q.push_back({m_last, m_data});
        if (ts_valid) ts_cnt++;
        if (status[3:0] == 4'd7) saw_drop = 1'b1;
    end

    function automatic logic [31:0] sw(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] hdr(input logic [3:0] typ, input bit t,
                                        input logic [3:0] seq,
                                        input logic [15:0] size);
        return {typ, 1'b0, t, 6'd0, seq, size};
    endfunction

    task automatic wt(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] d, input bit l);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        s_data = d;
        s_valid = 1'b1;
        s_last = l;
        while (!ok && n < 300) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #2;
            n++;
        end
        check("send_ready", ok, 1);
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic pkt(input int size, input bit t, input logic [3:0] seq,
                       input logic [31:0] id, input int last_at,
                       input bit fwd, input logic [3:0] typ);
        logic [31:0] w;
        for (int i = 0; i <= last_at; i++) begin
            if (i == 0)      w = hdr(typ, t, seq, 16'(size));
            else if (i == 1) w = id;
            else if (i == 2) w = 32'h5EC0_0000 | 32'(seq);
            else if (i == 3) w = 32'hF0F0_0000 | 32'(seq);
            else if (i == 4) w = 32'h0000_ABCD;
            else if (t && i == size - 1) w = 32'h1122_3344;
            else w = {8'hD0, 8'(pkt_n), 8'h00, 8'(i)};
            if (fwd && i >= 5 && i <= size - 1 - int'(t))
                exp_q.push_back({(i == last_at || i == size - 1 - int'(t)), w});
            send(sw(w), i == last_at);
        end
        pkt_n++;
    endtask

    task automatic drain(input string tag);
        int n;
        int m;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 400) begin
            @(posedge clk);
            n++;
        end
        wt(5);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        m = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            check({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic soft_reset();
        ctrl = 32'h3;
        wt(3);
        check("srst_clear", 64'(status[31:8]), 0);
        ctrl = 32'h1;
        wt(3);
    endtask

    initial begin
        wt(3);
        check("rst_status", 64'(status), 0);
        check("rst_mvalid", 64'(m_valid), 0);
        check("rst_sready", 64'(s_ready), 0);
        check("rst_sec", 64'(ts_sec), 0);
        check("rst_fsec", ts_fsec, 0);
        check("rst_trailer", 64'(trl), 0);
        rst_n = 1'b1;
        ctrl = 32'h1;
        wt(3);

        ts_cnt = 0;
        pkt(10, 1'b0, 4'd0, 32'h1, 9, 1'b1, 4'd1);
        drain("good");
        check("good_tscnt", 64'(ts_cnt), 1);
        check("good_sec", 64'(ts_sec), 64'h5EC0_0000);
        check("good_fsec", ts_fsec, 64'hF0F0_0000_0000_ABCD);
        check("good_cnt", 64'(status[31:16]), 1);
        check("good_state", 64'(status[3:0]), 0);

        pkt(10, 1'b1, 4'd1, 32'h1, 9, 1'b1, 4'd1);
        drain("trl");
        check("trl_word", 64'(trl), 64'h1122_3344);
        check("trl_cnt", 64'(status[31:16]), 2);

        soft_reset();
        rnd = 1'b1;
        for (int k = 0; k < 20; k++)
            pkt(8, 1'b0, 4'(k), 32'h1, 7, 1'b1, 4'd1);
        drain("rnd");
        rnd = 1'b0;
        wt(2);
        check("rnd_cnt", 64'(status[31:16]), 20);
        check("rnd_seqerr", 64'(status[8]), 0);

        soft_reset();
        pkt(8, 1'b0, 4'd3, 32'h1, 7, 1'b1, 4'd1);
        pkt(8, 1'b0, 4'd4, 32'h1, 7, 1'b1, 4'd1);
        pkt(8, 1'b0, 4'd6, 32'h1, 7, 1'b1, 4'd1);
        drain("seq");
        check("seq_err", 64'(status[8]), 1);
        check("seq_last", 64'(status[7:4]), 6);
        check("seq_cnt", 64'(status[31:16]), 2);
        pkt(8, 1'b0, 4'd7, 32'h1, 7, 1'b1, 4'd1);
        drain("seq7");
        check("seq_resync", 64'(status[31:16]), 3);

        soft_reset();
        pkt(10, 1'b0, 4'd0, 32'h1, 7, 1'b1, 4'd1);
        drain("early");
        check("early_len", 64'(status[9]), 1);
        check("early_cnt", 64'(status[31:16]), 0);
        ts_cnt = 0;
        pkt(10, 1'b0, 4'd1, 32'h1, 9, 1'b1, 4'd1);
        drain("after");
        check("after_cnt", 64'(status[31:16]), 1);
        check("after_ts", 64'(ts_cnt), 1);
        check("after_sec", 64'(ts_sec), 64'h5EC0_0001);

        saw_drop = 1'b0;
        pkt(8, 1'b0, 4'd2, 32'h1, 7, 1'b0, 4'd2);
        drain("type");
        check("type_err", 64'(status[10]), 1);
        check("type_drop", 64'(saw_drop), 1);

        soft_reset();
        sid = 32'hA5A5_A5A5;
        ctrl = 32'h9;
        wt(3);
        saw_drop = 1'b0;
        pkt(10, 1'b0, 4'd0, 32'h1, 9, 1'b0, 4'd1);
        drain("sid");
        check("sid_err", 64'(status[11]), 1);
        check("sid_drop", 64'(saw_drop), 1);
        check("sid_idle", 64'(status[3:0]), 0);
        check("sid_cnt", 64'(status[31:16]), 0);

        ctrl = 32'h5;
        wt(3);
        exp_q.push_back({1'b0, 32'h0102_0304});
        exp_q.push_back({1'b1, 32'h0506_0708});
        send(32'h0102_0304, 1'b0);
        send(32'h0506_0708, 1'b1);
        drain("pass");
        check("pass_idle", 64'(status[3:0]), 0);

        ctrl = 32'h1;
        hold = 1'b0;
        wt(3);
        for (int i = 0; i < 6; i++)
            send(sw(i == 0 ? hdr(4'd1, 1'b0, 4'd0, 16'd10)
                           : 32'hC0DE_0000 | 32'(i)), 1'b0);
        check("mid_mvalid", 64'(m_valid), 1);
        check("mid_state", 64'(status[3:0]), 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mvalid", 64'(m_valid), 0);
        check("arst_state", 64'(status[3:0]), 0);
        check("arst_sready", 64'(s_ready), 0);
        wt(2);
        rst_n = 1'b1;
        hold = 1'b1;
        wt(2);
        check("arst_noout", 64'(got_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
